uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//  Parametrised UART receiver: configurable data bits, parity and stop bits, 3-sample majority
//  voting, error tagging and a receive FIFO with a valid/ready drain port. Sits between the
//  host serial pin and the SPC700 debug/loader command decoder; absorbs back-to-back frames
//  while the consumer is busy.
// PARAMETERS
//  CLOCKS_PER_BIT  40  clocks per bit period; legal range 4..65535
//  DATA_BITS       8   data bits per frame; legal range 5..9; sent LSB first
//  PARITY          0   0 = none, 1 = odd, 2 = even
//  STOP_BITS       1   1 or 2
//  FIFO_DEPTH      4   receive FIFO entries; power of 2, >= 2
// PORTS
//  clock       in   1          rising-edge system clock
//  reset_n     in   1          asynchronous active-low reset
//  uart_data   in   1          serial line, idle high, asynchronous to clock
//  rx_data     out  DATA_BITS  head-of-FIFO data; valid while rx_valid = 1
//  rx_perr     out  1          head entry had a parity error (0 when PARITY = 0)
//  rx_ferr     out  1          head entry had a stop-bit (framing) error
//  rx_valid    out  1          FIFO not empty
//  rx_ready    in   1          consumer pops the head entry when rx_valid && rx_ready
//  overrun     out  1          sticky: a frame was dropped because the FIFO was full
//  clear_ovr   in   1          synchronous clear of overrun
// BEHAVIOUR
//  Reset (reset_n = 0, async): state = IDLE, FIFO empty, rx_valid = 0, rx_data = 0,
//   rx_perr = 0, rx_ferr = 0, overrun = 0, synchroniser flops = 1.
//  Input: 2-flop synchroniser; all decisions use the synchronised line (2-clock latency).
//  Bit-period counter width = $clog2(CLOCKS_PER_BIT). MID = (CLOCKS_PER_BIT-1)/2.
//  Majority sample per bit = majority of the line at counter MID-1, MID, MID+1.
//  FSM:
//   IDLE: on a synchronised 1->0 edge, counter <= 0 -> START.
//   START: at counter MID+1, evaluate the majority. If it is 1, the start is false -> IDLE, and
//    nothing is pushed. Otherwise continue to counter CLOCKS_PER_BIT-1, then -> DATA with
//    bit index 0.
//   DATA: per bit, take the majority at MID+1 and shift it in LSB first. At counter
//    CLOCKS_PER_BIT-1: if index = DATA_BITS-1 -> PARITY (PARITY != 0) or STOP; else index++.
//   PARITY: the majority bit XOR data must give odd (1) or even (2) total ones; mismatch sets
//    the frame perr. Then -> STOP.
//   STOP: each stop bit's majority must be 1, else set the frame ferr. The push happens at
//    counter MID+1 of the last stop bit, so the next start edge can be caught. If any stop
//    bit was 0 -> WAIT_HIGH; else -> IDLE.
//   WAIT_HIGH: stay until the synchronised line is 1 (break or garbage), then -> IDLE.
//  Push: a single-cycle write of {data, perr, ferr}. Errored frames are pushed, not dropped.
//  Pop: rx_valid && rx_ready advances the read pointer. The FIFO is first-word-fall-through:
//   the head is visible on the cycle after the push into an empty FIFO.
//  Full FIFO with a push and no pop in the same cycle: the frame is dropped, overrun <= 1,
//   and FIFO contents are unchanged.
//  Full FIFO with a push and a pop in the same cycle: both occur, count unchanged, no overrun.
//  Empty FIFO with a push and rx_ready = 1: no pop this cycle, because rx_valid is 0.
//  overrun and clear_ovr in the same cycle: the set wins.
//  Pointers wrap modulo FIFO_DEPTH; count width = $clog2(FIFO_DEPTH)+1.
//  reset_n asserted mid-frame: the partial frame is discarded and the FIFO is flushed.
// TESTING  (CLOCKS_PER_BIT = 16 unless stated)
//  1. 8N1, send 0xA5, rx_ready = 1 -> exactly one rx_valid cycle, rx_data = 0xA5,
//     perr = ferr = 0.
//  2. 8E1, send 0x03 with parity bit 1 -> rx_data = 0x03, rx_perr = 1; the next correct
//     frame 0x07 (parity 1) -> perr = 0.
//  3. Stop bit forced 0, then the line is held low for 30 bit times -> one entry with
//     ferr = 1, data = 0x00; no further entries until the line returns high and a new start
//     bit arrives.
//  4. Glitch: line low for 3 clocks only -> no push, FSM back in IDLE. A single-clock 0 in the
//     middle of a data bit of 0xFF -> 0xFF still received.
//  5. FIFO_DEPTH = 4, rx_ready = 0, send 5 frames 0x01..0x05 -> entries 0x01..0x04 retained,
//     overrun = 1. Pop all -> order 0x01..0x04. clear_ovr -> overrun = 0.
//  6. DATA_BITS = 9, STOP_BITS = 2, CLOCKS_PER_BIT = 5, back-to-back frames 0x1FF, 0x000 ->
//     both received. Assert reset_n mid-frame -> rx_valid = 0 immediately, no residual push.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   UART receiver with a small receive FIFO. Frames are oversampled at
//   CLOCKS_PER_BIT clocks per bit. Each bit is decided by a 3-sample majority
//   vote around the bit centre. Parity and stop-bit errors are tagged on the
//   entry rather than dropping the frame.
//
// Ports
//   clock      in   rising-edge system clock
//   reset_n    in   asynchronous active-low reset
//   uart_data  in   serial line, idle high, asynchronous to clock
//   rx_data    out  head-of-FIFO data (0 while rx_valid = 0)
//   rx_perr    out  head entry had a parity error
//   rx_ferr    out  head entry had a framing (stop-bit) error
//   rx_valid   out  FIFO not empty
//   rx_ready   in   consumer accepts the head entry
//   overrun    out  sticky: a frame was dropped because the FIFO was full
//   clear_ovr  in   synchronous clear of overrun (a same-cycle set wins)
//   dbg_state  out  current receiver FSM state (state_t encoding)
//
// Handshake: the head entry transfers on every rising clock edge where
// rx_valid && rx_ready. rx_valid does not depend on rx_ready. The head
// entry stays stable until it is transferred.

module uart_rx_fifo #(
    parameter int CLOCKS_PER_BIT = 40,
    parameter int DATA_BITS      = 8,
    parameter int PARITY         = 0,
    parameter int STOP_BITS      = 1,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 uart_data,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_perr,
    output logic                 rx_ferr,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 overrun,
    input  logic                 clear_ovr,
    output logic [2:0]           dbg_state
);

    localparam int CNT_W   = $clog2(CLOCKS_PER_BIT);
    localparam int MID     = (CLOCKS_PER_BIT - 1) / 2;
    localparam int IDX_W   = $clog2(DATA_BITS);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNTF_W  = PTR_W + 1;
    localparam int ENTRY_W = DATA_BITS + 2;

    localparam logic [CNT_W-1:0] SAMP_A   = CNT_W'(MID - 1);
    localparam logic [CNT_W-1:0] SAMP_B   = CNT_W'(MID);
    localparam logic [CNT_W-1:0] SAMP_C   = CNT_W'(MID + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic             ODD_PAR  = (PARITY == 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;
    localparam logic [CNTF_W-1:0] FIFO_FULL = CNTF_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser and edge detect
    // ------------------------------------------------------------------
    logic sync_1, sync_2, line_q;
    logic line;

    assign line = sync_2;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            line_q <= 1'b1;
        end else begin
            sync_1 <= uart_data;
            sync_2 <= sync_1;
            line_q <= sync_2;
        end
    end

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    state_t               state, state_n;
    logic [CNT_W-1:0]     bit_cnt, cnt_n;
    logic [IDX_W-1:0]     bit_idx, idx_n;
    logic                 stop_idx, stop_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 frame_perr, perr_n;
    logic                 frame_ferr, ferr_n;
    logic                 samp_a, samp_b;
    logic                 maj;
    logic                 at_samp, at_last;
    logic                 push, push_ferr;

    // The first two votes are registered; the third is the live line at
    // MID+1, so the decision is available in the same cycle as the last vote.
    assign maj     = (samp_a & samp_b) | (samp_a & line) | (samp_b & line);
    assign at_samp = (bit_cnt == SAMP_C);
    assign at_last = (bit_cnt == CNT_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            shreg      <= '0;
            frame_perr <= 1'b0;
            frame_ferr <= 1'b0;
            samp_a     <= 1'b1;
            samp_b     <= 1'b1;
        end else begin
            state      <= state_n;
            bit_cnt    <= cnt_n;
            bit_idx    <= idx_n;
            stop_idx   <= stop_n;
            shreg      <= shreg_n;
            frame_perr <= perr_n;
            frame_ferr <= ferr_n;
            if (bit_cnt == SAMP_A) samp_a <= line;
            if (bit_cnt == SAMP_B) samp_b <= line;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = at_last ? '0 : bit_cnt + 1'b1;
        idx_n     = bit_idx;
        stop_n    = stop_idx;
        shreg_n   = shreg;
        perr_n    = frame_perr;
        ferr_n    = frame_ferr;
        push      = 1'b0;
        push_ferr = 1'b0;

        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                if (line_q && !line) begin
                    state_n = ST_START;
                    idx_n   = '0;
                    stop_n  = 1'b0;
                    perr_n  = 1'b0;
                    ferr_n  = 1'b0;
                end
            end
            ST_START: begin
                // A start bit that votes high at its centre was a glitch.
                if (at_samp && maj) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else if (at_last) begin
                    state_n = ST_DATA;
                    idx_n   = '0;
                end
            end
            ST_DATA: begin
                // LSB first: shift in from the top so the first bit ends at bit 0.
                if (at_samp) shreg_n = {maj, shreg[DATA_BITS-1:1]};
                if (at_last) begin
                    if (bit_idx == IDX_LAST) begin
                        state_n = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_n = bit_idx + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (at_samp) perr_n = ((^shreg) ^ maj) != ODD_PAR;
                if (at_last) state_n = ST_STOP;
            end
            ST_STOP: begin
                if (at_samp) begin
                    if (!maj) ferr_n = 1'b1;
                    // Push at the centre of the last stop bit so a start bit
                    // immediately following is still caught from IDLE.
                    if (stop_idx == STOP_LAST) begin
                        push      = 1'b1;
                        push_ferr = frame_ferr | ~maj;
                        state_n   = push_ferr ? ST_WAIT_HIGH : ST_IDLE;
                        cnt_n     = '0;
                    end
                end else if (at_last) begin
                    stop_n = 1'b1;
                end
            end
            ST_WAIT_HIGH: begin
                // Line held low (break): wait for idle before hunting a start.
                cnt_n = '0;
                if (line) state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign dbg_state = state;

    // ------------------------------------------------------------------
    // Receive FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNTF_W-1:0]  fifo_cnt;
    logic               full, pop, wr_en;
    logic [ENTRY_W-1:0] head;

    assign full  = (fifo_cnt == FIFO_FULL);
    assign pop   = rx_valid & rx_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign wr_en = push & (~full | pop);

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr] <= {shreg, frame_perr, push_ferr};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            overrun  <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (push && full && !pop) overrun <= 1'b1;
            else if (clear_ovr)       overrun <= 1'b0;
        end
    end

    assign rx_valid = (fifo_cnt != '0);
    assign head     = mem[rd_ptr];
    assign rx_data  = rx_valid ? head[ENTRY_W-1:2] : '0;
    assign rx_perr  = rx_valid & head[1];
    assign rx_ferr  = rx_valid & head[0];

endmodule
